// File: rtl/fp_convert_seq_if.sv
// Handshake bundle for the 12-bit to 8-bit floating-point conversion sequencer.
// The producer drives D/in_valid. The consumer drives out_ready.
// The sequencer drives everything else.
interface fp_convert_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] D;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        busy;

  // Front end / back end view: supplies samples and accepts results
  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, busy
  );

  // Sequencer view
  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, busy
  );
endinterface

// File: rtl/fp_convert_seq.sv
// Multi-cycle 12-bit two's-complement to S/E/F (1/3/4) floating-point converter.
// The datapath works in four steps:
//   1. Take the magnitude of the sample.
//   2. Normalise it one bit per clock while counting the exponent down.
//   3. Round on the fifth bit, with exponent carry and saturation.
//   4. Hold the result until the consumer takes it.
module fp_convert_seq (
  input  logic               clk,
  input  logic               rst,
  fp_convert_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic        sign_reg, sign_next;
  logic        sat_reg, sat_next;
  logic [10:0] w_reg, w_next;
  logic [2:0]  ecnt_reg, ecnt_next;
  logic        s_reg, s_next;
  logic [2:0]  e_reg, e_next;
  logic [3:0]  f_reg, f_next;

  logic [11:0] mag;
  logic [3:0]  frac;
  logic        fifth;
  logic        norm_step;

  // The magnitude of -2048 is 12'h800, which only fits because mag keeps all 12 bits.
  assign mag   = bus.D[11] ? (~bus.D + 12'd1) : bus.D;
  assign frac  = w_reg[10:7];
  assign fifth = w_reg[6];

  // Keep shifting until the leading one reaches bit 10 or the exponent bottoms out.
  assign norm_step = !sat_reg && !w_reg[10] && (ecnt_reg != 3'd0);

  // The handshake outputs decode straight from state, so reset clears them at once.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.S         = s_reg;
  assign bus.E         = e_reg;
  assign bus.F         = f_reg;

  // State and datapath registers; rst aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sign_reg  <= 1'b0;
      sat_reg   <= 1'b0;
      w_reg     <= 11'd0;
      ecnt_reg  <= 3'd0;
      s_reg     <= 1'b0;
      e_reg     <= 3'd0;
      f_reg     <= 4'd0;
    end else begin
      state_reg <= state_next;
      sign_reg  <= sign_next;
      sat_reg   <= sat_next;
      w_reg     <= w_next;
      ecnt_reg  <= ecnt_next;
      s_reg     <= s_next;
      e_reg     <= e_next;
      f_reg     <= f_next;
    end
  end

  // Next-state and datapath update for each sequencing step.
  always_comb begin
    state_next = state_reg;
    sign_next  = sign_reg;
    sat_next   = sat_reg;
    w_next     = w_reg;
    ecnt_next  = ecnt_reg;
    s_next     = s_reg;
    e_next     = e_reg;
    f_next     = f_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next  = bus.D[11];
          sat_next   = (mag == 12'h800);
          w_next     = mag[10:0];
          ecnt_next  = 3'd7;
          state_next = NORM;
        end
      end

      NORM: begin
        if (norm_step) begin
          w_next    = {w_reg[9:0], 1'b0};
          ecnt_next = ecnt_reg - 3'd1;
        end else begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        s_next = sign_reg;
        if (sat_reg) begin
          e_next = 3'd7;
          f_next = 4'b1111;
        end else if (!fifth) begin
          e_next = ecnt_reg;
          f_next = frac;
        end else if (frac != 4'b1111) begin
          e_next = ecnt_reg;
          f_next = frac + 4'd1;
        end else if (ecnt_reg != 3'd7) begin
          // The significand overflowed, so renormalise into the next exponent.
          e_next = ecnt_reg + 3'd1;
          f_next = 4'b1000;
        end else begin
          // The exponent has no headroom left, so clamp to the largest code.
          e_next = 3'd7;
          f_next = 4'b1111;
        end
        state_next = DONE;
      end

      DONE: begin
        // A new sample is not accepted here, even alongside out_ready.
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed-vector bench for fp_convert_seq with hand-computed S/E/F and latency.
module tb_fp_convert_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fp_convert_seq_if bus ();

  fp_convert_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the result.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample and wait for the result. Latency is counted in edges after the accept edge.
  task automatic convert(input string tag, input logic [11:0] d, input logic exp_s,
                         input logic [2:0] exp_e, input logic [3:0] exp_f,
                         input int exp_lat, input bit release_out);
    int lat;
    bus.D        = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq({tag, "_inready_low"}, bus.in_ready, 1'b0);
    check_eq({tag, "_busy"}, bus.busy, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_S"}, bus.S, exp_s);
    check_eq({tag, "_E"}, bus.E, exp_e);
    check_eq({tag, "_F"}, bus.F, exp_f);
    $display("%s: D=%h -> S=%0b E=%0d F=%b lat=%0d", tag, d, bus.S, bus.E, bus.F, lat);
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_eq({tag, "_outvalid_clr"}, bus.out_valid, 1'b0);
      check_eq({tag, "_idle"}, bus.in_ready, 1'b1);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.D         = 12'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outvalid", bus.out_valid, 1'b0);
    check_eq("rst_inready", bus.in_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_SEF", {bus.S, bus.E, bus.F}, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    convert("pos422", 12'h1A6, 1'b0, 3'd5, 4'b1101, 4, 1'b1);
    convert("neg422", 12'hE5A, 1'b1, 3'd5, 4'b1101, 4, 1'b1);
    convert("zero",   12'h000, 1'b0, 3'd0, 4'b0000, 9, 1'b1);
    convert("d125",   12'd125, 1'b0, 3'd4, 4'b1000, 6, 1'b1);
    convert("d2047",  12'd2047, 1'b0, 3'd7, 4'b1111, 2, 1'b1);
    convert("m2048",  12'h800, 1'b1, 3'd7, 4'b1111, 2, 1'b1);

    // Backpressure: the result must hold while in_valid/D are toggled.
    convert("bp", 12'h1A6, 1'b0, 3'd5, 4'b1101, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.D        = 12'h07F + 12'(i);
      @(posedge clk); #1;
      check_eq("bp_hold_SEF", {bus.S, bus.E, bus.F}, {1'b0, 3'd5, 4'b1101});
      check_eq("bp_outvalid", bus.out_valid, 1'b1);
      check_eq("bp_inready", bus.in_ready, 1'b0);
      $display("bp cycle %0d: out_valid=%0b in_ready=%0b", i, bus.out_valid, bus.in_ready);
    end
    // Release together with in_valid: only the output handshake completes.
    bus.in_valid  = 1'b1;
    bus.D         = 12'd125;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("bp_release_idle", bus.in_ready, 1'b1);
    check_eq("bp_release_busy", bus.busy, 1'b0);
    check_eq("bp_release_outvalid", bus.out_valid, 1'b0);
    check_eq("bp_release_SEF", {bus.S, bus.E, bus.F}, {1'b0, 3'd5, 4'b1101});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of NORM.
    bus.D        = 12'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_outvalid", bus.out_valid, 1'b0);
    check_eq("arst_busy", bus.busy, 1'b0);
    check_eq("arst_inready", bus.in_ready, 1'b1);
    check_eq("arst_SEF", {bus.S, bus.E, bus.F}, 8'h00);
    $display("arst: busy=%0b in_ready=%0b SEF=%h", bus.busy, bus.in_ready, {bus.S, bus.E, bus.F});
    rst = 1'b0;
    @(posedge clk); #1;
    convert("d5", 12'd5, 1'b0, 3'd0, 4'b0101, 9, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_convert_seq.md
Name: fp_convert_seq

Overview:
- Multi-cycle sequencer for the 12-bit to 8-bit floating-point conversion path.
- Accepts a 12-bit two's-complement sample through a valid/ready handshake and computes sign-magnitude.
- Normalises by shifting one bit per clock while counting the exponent down.
- Rounds on the fifth bit, with exponent carry and saturation, and presents S/E/F through a valid/ready output handshake.
- Sits between the switch/sample front end and the display/encoder back end.

Parameters:
None. Widths are fixed: D is 12 bits; S/E/F are 1/3/4 bits.

Ports:
clk        input   1   system clock, rising edge
rst        input   1   asynchronous, active-high reset
in_valid   input   1   D is valid
in_ready   output  1   block can accept D
D          input   12  two's-complement input sample
out_valid  output  1   S/E/F are valid
out_ready  input   1   consumer accepts S/E/F
S          output  1   sign bit
E          output  3   exponent
F          output  4   significand
busy       output  1   high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - S=0, E=0, F=0, out_valid=0, in_ready=1, busy=0.
  - Internal work register and flags cleared.
  - Asserting rst in any state aborts the conversion with no output.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1:
    - Latch sign=D[11] and mag=|D| (12 bits).
    - sat=(mag==12'h800).
    - W=mag[10:0], ecnt=7.
    - Go to NORM.
- NORM (in_ready=0):
  - Each edge: if !sat && W[10]==0 && ecnt!=0, then W<=W<<1 (shift in zero) and ecnt<=ecnt-1; stay in NORM.
  - Otherwise go to ROUND.
  - At most 7 shifts.
- ROUND (one cycle):
  - f=W[10:7], fifth=W[6].
  - If sat: E=7, F=4'b1111.
  - Else if fifth==0: E=ecnt, F=f.
  - Else if f!=4'b1111: E=ecnt, F=f+1.
  - Else if ecnt!=7: F=4'b1000, E=ecnt+1.
  - Else: E=7, F=4'b1111 (saturate).
  - S=sign; go to DONE.
- DONE:
  - out_valid=1; S/E/F held stable.
  - in_valid is ignored and in_ready=0.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - S/E/F keep their last value after the handshake.
- Latency from the accept edge to out_valid high is k+2 edges, where k is the number of NORM shifts (0..7).
  - Range is 2..9.
  - Minimum initiation interval is k+4 edges, because in_ready is low outside IDLE.
- Arithmetic rules:
  - mag is the 12-bit unsigned two's-complement negation when D[11]=1.
  - -2048 sets sat and skips normalisation.
  - Magnitudes below 16 end with ecnt=0 and F=mag[3:0], fifth=0.
- Zero input: S=0, E=0, F=0.
  - Negative zero cannot occur.
- Simultaneous events:
  - rst overrides everything.
  - In DONE, out_ready and in_valid in the same cycle: only the output handshake completes; D is accepted no earlier than the following IDLE cycle.

Test Plan:
- D=12'd422 (0x1A6) → 2 shifts; S=0, E=5, F=1101; out_valid high 4 edges after accept.
- D=12'hE5A (-422) → S=1, E=5, F=1101. D=12'd0 → S=0, E=0, F=0 after 9 edges.
- D=12'd125 → f=1111 with fifth=1, so the round carries: S=0, E=4, F=1000.
- D=12'd2047 → S=0, E=7, F=1111 (round saturates). D=12'h800 → S=1, E=7, F=1111 with 0 shifts (latency 2).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/D.
  - S/E/F stay stable; out_valid=1, in_ready=0, and no new accept.
  - Release out_ready → IDLE on the next edge.
- Assert rst for 1 ns mid-NORM, asynchronous to clk, with D=12'd5.
  - out_valid=0, busy=0, in_ready=1 and S/E/F=0 immediately.
  - After reset release, D=12'd5 converts to S=0, E=0, F=0101.
